// File: rtl/mips_instr_encoder.sv
// Loads a program into instruction memory by encoding symbolic MIPS requests
// into 32-bit words and writing them to consecutive word addresses over an acked port.
module mips_instr_encoder #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    MAX_WORDS  = 64
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               req_valid_in,
  output logic                               req_ready_out,
  input  logic [2:0]                         op_sel_in,
  input  logic [4:0]                         rs_in,
  input  logic [4:0]                         rt_in,
  input  logic [4:0]                         rd_in,
  input  logic [15:0]                        imm_in,
  output logic                               mem_we_out,
  output logic [ADDR_WIDTH-1:0]              mem_addr_out,
  output logic [31:0]                        mem_data_out,
  input  logic                               mem_ack_in,
  input  logic                               clear_in,
  output logic [$clog2(MAX_WORDS+1)-1:0]     count_out,
  output logic                               full_out
);

  localparam int CW = $clog2(MAX_WORDS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             data_q, data_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    full_q, full_d;
  logic [CW-1:0]           count_inc_s;
  logic [ADDR_WIDTH-1:0]   next_addr_s;

  // Unused fields of each format are replaced by constants so they never leak.
  function automatic logic [31:0] encode_instr(
    input logic [2:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [15:0] imm
  );
    logic [31:0] word;
    case (op)
      3'd0:    word = 32'h0000_0000;
      3'd1:    word = {6'h00, rs, rt, rd, 5'h00, 6'h20};
      3'd2:    word = {6'h00, rs, rt, rd, 5'h00, 6'h22};
      3'd3:    word = {6'h00, rs, rt, rd, 5'h00, 6'h2a};
      3'd4:    word = {6'h00, rs, rt, rd, 5'h00, 6'h27};
      3'd5:    word = {6'h08, rs, rt, imm};
      3'd6:    word = {6'h0c, rs, rt, imm};
      3'd7:    word = {6'h0f, 5'h00, rt, imm};
      default: word = 32'h0000_0000;
    endcase
    return word;
  endfunction

  assign count_inc_s   = count_q + CW'(1);
  assign next_addr_s   = BASE_ADDR + (ADDR_WIDTH'(count_q) << 2);
  assign req_ready_out = reset_n & (state_q == IDLE) & ~clear_in;

  // Next-state and output-register computation for the load sequencer.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    count_d = count_q;
    full_d  = full_q;
    case (state_q)
      IDLE: begin
        if (clear_in) begin
          count_d = '0;
          full_d  = 1'b0;
        end else if (req_valid_in) begin
          data_d  = encode_instr(op_sel_in, rs_in, rt_in, rd_in, imm_in);
          addr_d  = next_addr_s;
          we_d    = 1'b1;
          state_d = WRITE;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        // clear_in deliberately ignored here so an in-flight write always lands.
        if (mem_ack_in) begin
          we_d    = 1'b0;
          count_d = count_inc_s;
          if (count_inc_s == CW'(MAX_WORDS)) begin
            state_d = FULL;
            full_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = WRITE;
        end
      end
      FULL: begin
        if (clear_in) begin
          count_d = '0;
          full_d  = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = FULL;
        end
      end
      default: begin
        state_d = IDLE;
        we_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any write in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= 32'h0000_0000;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  assign mem_we_out   = we_q;
  assign mem_addr_out = addr_q;
  assign mem_data_out = data_q;
  assign count_out    = count_q;
  assign full_out     = full_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed plus randomized checks of mips_instr_encoder against an arithmetic
// reference model of the MIPS field layout and the word-address sequence.
module tb_mips_instr_encoder;

  localparam int          AW   = 32;
  localparam logic [31:0] BASE = 32'hFFFF_FFF8;
  localparam int          MAXW = 4;
  localparam int          CW   = $clog2(MAXW + 1);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid_in;
  logic          req_ready_out;
  logic [2:0]    op_sel_in;
  logic [4:0]    rs_in, rt_in, rd_in;
  logic [15:0]   imm_in;
  logic          mem_we_out;
  logic [AW-1:0] mem_addr_out;
  logic [31:0]   mem_data_out;
  logic          mem_ack_in;
  logic          clear_in;
  logic [CW-1:0] count_out;
  logic          full_out;

  int n_assert = 0;
  int n_fail   = 0;
  int model_count = 0;

  mips_instr_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .op_sel_in(op_sel_in), .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .imm_in(imm_in),
    .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out),
    .mem_ack_in(mem_ack_in), .clear_in(clear_in),
    .count_out(count_out), .full_out(full_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Field weights: opcode<<26, rs<<21, rt<<16, rd<<11, as plain multiplication.
  function automatic logic [31:0] ref_encode(input int op, input int rs, input int rt,
                                             input int rd, input int imm);
    longint unsigned w;
    longint unsigned k_op = 64'd67108864;
    longint unsigned k_rs = 64'd2097152;
    longint unsigned k_rt = 64'd65536;
    longint unsigned k_rd = 64'd2048;
    case (op)
      1: w = rs * k_rs + rt * k_rt + rd * k_rd + 32;
      2: w = rs * k_rs + rt * k_rt + rd * k_rd + 34;
      3: w = rs * k_rs + rt * k_rt + rd * k_rd + 42;
      4: w = rs * k_rs + rt * k_rt + rd * k_rd + 39;
      5: w = 8  * k_op + rs * k_rs + rt * k_rt + imm;
      6: w = 12 * k_op + rs * k_rs + rt * k_rt + imm;
      7: w = 15 * k_op + rt * k_rt + imm;
      default: w = 0;
    endcase
    return w[31:0];
  endfunction

  function automatic logic [31:0] exp_addr(input int c);
    longint unsigned a;
    a = longint'(BASE) + 4 * c;
    return a[31:0];
  endfunction

  task automatic drive_fields(input int op, input int rs, input int rt, input int rd, input int imm);
    op_sel_in = 3'(op);
    rs_in     = 5'(rs);
    rt_in     = 5'(rt);
    rd_in     = 5'(rd);
    imm_in    = 16'(imm);
  endtask

  task automatic do_write(input string tag, input int op, input int rs, input int rt,
                          input int rd, input int imm, input int ack_dly);
    logic [31:0] ew, ea;
    int waited;
    ew = ref_encode(op, rs, rt, rd, imm);
    ea = exp_addr(model_count);
    waited = 0;
    while (req_ready_out !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    check({tag, "_ready_idle"}, 32'(req_ready_out), 32'd1);
    req_valid_in = 1'b1;
    drive_fields(op, rs, rt, rd, imm);
    tick();
    req_valid_in = 1'b0;
    drive_fields(int'($urandom), int'($urandom), int'($urandom), int'($urandom), int'($urandom));
    check({tag, "_we"},   32'(mem_we_out), 32'd1);
    check({tag, "_addr"}, mem_addr_out, ea);
    check({tag, "_data"}, mem_data_out, ew);
    check({tag, "_ready_wr"}, 32'(req_ready_out), 32'd0);
    for (int i = 0; i < ack_dly; i++) begin
      clear_in = (i == 0) ? 1'b1 : 1'b0;
      tick();
      clear_in = 1'b0;
      check({tag, "_hold_we"},   32'(mem_we_out), 32'd1);
      check({tag, "_hold_addr"}, mem_addr_out, ea);
      check({tag, "_hold_data"}, mem_data_out, ew);
      check({tag, "_hold_ready"}, 32'(req_ready_out), 32'd0);
    end
    mem_ack_in = 1'b1;
    tick();
    mem_ack_in = 1'b0;
    model_count++;
    check({tag, "_we_done"}, 32'(mem_we_out), 32'd0);
    check({tag, "_count"},   32'(count_out), 32'(model_count));
    check({tag, "_full"},    32'(full_out), (model_count == MAXW) ? 32'd1 : 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; req_valid_in = 1'b0; mem_ack_in = 1'b0; clear_in = 1'b0;
    drive_fields(0, 0, 0, 0, 0);
    #1;
    check("rst_ready", 32'(req_ready_out), 32'd0);
    check("rst_we",    32'(mem_we_out), 32'd0);
    check("rst_addr",  mem_addr_out, 32'd0);
    check("rst_data",  mem_data_out, 32'd0);
    check("rst_count", 32'(count_out), 32'd0);
    check("rst_full",  32'(full_out), 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    #1;
    check("post_rst_ready", 32'(req_ready_out), 32'd1);

    do_write("add", 1, 1, 2, 3, 0, 0);
    check("add_word_const", mem_data_out, 32'h0022_1820);

    // ack outside WRITE must have no effect
    mem_ack_in = 1'b1;
    tick();
    mem_ack_in = 1'b0;
    check("idle_ack_count", 32'(count_out), 32'(model_count));
    check("idle_ack_we",    32'(mem_we_out), 32'd0);

    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    model_count = 0;
    check("clear_count", 32'(count_out), 32'd0);

    do_write("sub", 2, 1, 2, 4, 0, 0);
    check("sub_word_const", mem_data_out, 32'h0022_2022);
    do_write("slt", 3, 1, 2, 6, 0, 0);
    check("slt_word_const", mem_data_out, 32'h0022_302A);
    do_write("nor", 4, 1, 2, 5, 0, 0);
    check("nor_word_const", mem_data_out, 32'h0022_2827);
    check("stream_count", 32'(count_out), 32'd3);
    do_write("addi", 5, 0, 8, 17, 5, 0);
    check("addi_word_const", mem_data_out, 32'h2008_0005);
    check("full_ready", 32'(req_ready_out), 32'd0);

    // fifth request stalls while full, then is taken after clear
    req_valid_in = 1'b1;
    drive_fields(6, 8, 9, 3, 16'h00FF);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_we",    32'(mem_we_out), 32'd0);
      check("stall_count", 32'(count_out), 32'd4);
      check("stall_full",  32'(full_out), 32'd1);
    end
    clear_in = 1'b1;
    #1;
    check("clear_ready_low", 32'(req_ready_out), 32'd0);
    tick();
    clear_in = 1'b0;
    model_count = 0;
    check("full_clear_count", 32'(count_out), 32'd0);
    check("full_clear_full",  32'(full_out), 32'd0);
    check("full_clear_we",    32'(mem_we_out), 32'd0);
    tick();
    req_valid_in = 1'b0;
    check("stalled_we",   32'(mem_we_out), 32'd1);
    check("stalled_addr", mem_addr_out, BASE);
    check("stalled_data", mem_data_out, 32'h3109_00FF);
    mem_ack_in = 1'b1;
    tick();
    mem_ack_in = 1'b0;
    model_count = 1;
    check("stalled_count", 32'(count_out), 32'd1);

    do_write("lui", 7, 7, 1, 9, 16'h1001, 5);
    check("lui_word_const", mem_data_out, 32'h3C01_1001);

    // clear wins over a simultaneous request
    req_valid_in = 1'b1;
    clear_in = 1'b1;
    drive_fields(1, 3, 3, 3, 0);
    #1;
    check("clr_req_ready", 32'(req_ready_out), 32'd0);
    tick();
    req_valid_in = 1'b0;
    clear_in = 1'b0;
    model_count = 0;
    check("clr_req_we",    32'(mem_we_out), 32'd0);
    check("clr_req_count", 32'(count_out), 32'd0);

    // reset in the middle of a write
    do_write("pre_rst", 1, 4, 5, 6, 0, 0);
    req_valid_in = 1'b1;
    drive_fields(2, 9, 9, 9, 0);
    tick();
    req_valid_in = 1'b0;
    check("midwr_we_before", 32'(mem_we_out), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("midwr_we_async", 32'(mem_we_out), 32'd0);
    check("midwr_count",    32'(count_out), 32'd0);
    check("midwr_ready",    32'(req_ready_out), 32'd0);
    tick();
    reset_n = 1'b1;
    model_count = 0;

    for (int n = 0; n < 24; n++) begin
      if (model_count == MAXW) begin
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        model_count = 0;
        check("rnd_clear_count", 32'(count_out), 32'd0);
      end
      do_write("rnd", int'($urandom_range(0, 7)), int'($urandom_range(0, 31)),
               int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
               int'($urandom_range(0, 65535)), int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
